single_spi_rx: RTL

- Oversampled SPI slave receiver; the receiving end of the single-lane SPI transmitters (CS active-low, MSB first, data launched on SCLK falling edge and sampled on SCLK rising edge, i.e. mode 0).
- Sits on the iClk domain of a board, or in loopback/readback logic, capturing frames from an external SPI master.
- Delivers each frame as a right-aligned word with a bit count, a one-cycle valid strobe and a width-mismatch/overflow error flag.

---
 rtl/single_spi_rx_if.sv | 16 +
 rtl/single_spi_rx.sv | 86 ++++++++
 2 files changed

// File: rtl/single_spi_rx_if.sv
// single_spi_rx_if: SPI pins, expected width and received-frame outputs of the SPI receiver.
interface single_spi_rx_if #(parameter int MAXWIDTH = 128);
    logic                iSClk;
    logic                iCSn;
    logic                iSData;
    logic [7:0]          iDataWidth;
    logic [MAXWIDTH-1:0] oData;
    logic [7:0]          oBitCount;
    logic                oValid;
    logic                oError;
    logic                oBusy;
    modport master (output iSClk, iCSn, iSData, iDataWidth,
                    input  oData, oBitCount, oValid, oError, oBusy);
    modport slave  (input  iSClk, iCSn, iSData, iDataWidth,
                    output oData, oBitCount, oValid, oError, oBusy);
endinterface

// File: rtl/single_spi_rx.sv
// single_spi_rx: oversampled mode-0 SPI slave receiver delivering right-aligned frames
// with bit count, one-cycle valid strobe and width-mismatch/overflow error.
module single_spi_rx #(parameter int MAXWIDTH = 128) (
    input logic           iClk,
    input logic           iRst,
    single_spi_rx_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t              r_state;
    logic [2:0]          r_sclk;
    logic [2:0]          r_csn;
    logic [1:0]          r_sd;
    logic [1:0]          r_warm;
    logic                r_armed;
    logic [MAXWIDTH-1:0] r_shift;
    logic [7:0]          r_count;
    logic                r_ovf;
    logic [MAXWIDTH-1:0] r_data;
    logic [7:0]          r_bitcnt;
    logic                r_valid;
    logic                r_error;
    logic                w_sclk_rise;
    logic                w_cs_fall;
    logic                w_cs_rise;
    assign w_sclk_rise   = r_sclk[1] & ~r_sclk[2];
    assign w_cs_fall     = ~r_csn[1] & r_csn[2];
    assign w_cs_rise     = r_csn[1] & ~r_csn[2];
    assign bus.oData     = r_data;
    assign bus.oBitCount = r_bitcnt;
    assign bus.oValid    = r_valid;
    assign bus.oError    = r_error;
    assign bus.oBusy     = (r_state != S_IDLE);
    // r_warm keeps the reset value of the CSn synchroniser from arming the receiver
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_sclk   <= 3'b000;
            r_csn    <= 3'b111;
            r_sd     <= 2'b00;
            r_warm   <= 2'b00;
            r_armed  <= 1'b0;
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_count  <= 8'd0;
            r_ovf    <= 1'b0;
            r_data   <= '0;
            r_bitcnt <= 8'd0;
            r_valid  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_sclk  <= {r_sclk[1:0], bus.iSClk};
            r_csn   <= {r_csn[1:0], bus.iCSn};
            r_sd    <= {r_sd[0], bus.iSData};
            r_warm  <= {r_warm[0], 1'b1};
            r_valid <= 1'b0;
            if (r_warm[1] && r_csn[1])
                r_armed <= 1'b1;
            case (r_state)
                S_IDLE: if (w_cs_fall && r_armed) begin
                    r_shift <= '0;
                    r_count <= 8'd0;
                    r_ovf   <= 1'b0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_sclk_rise) begin
                        r_count <= (&r_count) ? r_count : r_count + 8'd1;
                        if (r_count < 8'(MAXWIDTH))
                            r_shift <= {r_shift[MAXWIDTH-2:0], r_sd[1]};
                        else
                            r_ovf <= 1'b1;
                    end
                    if (w_cs_rise)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_data   <= r_shift;
                    r_bitcnt <= r_count;
                    r_valid  <= 1'b1;
                    r_error  <= r_ovf | (r_count != bus.iDataWidth);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
